// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-time game round sequencer.
// Holds the state encoding, the LFSR tap mask and the default timing parameters.
package reaction_game_ctrl_pkg;

  localparam int unsigned DEFAULT_TIME_WIDTH = 10;
  localparam int unsigned DEFAULT_MIN_WAIT   = 256;

  // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_GO     = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_FOUL   = 3'd4;

  typedef enum logic [2:0] {
    StIdle   = S_IDLE,
    StWait   = S_WAIT,
    StGo     = S_GO,
    StResult = S_RESULT,
    StFoul   = S_FOUL
  } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider: one Tick every 2^PRESCALE_BITS enabled clocks.
// Clear has priority over counting so a new phase always starts from zero.
module tick_prescaler #(
  parameter int unsigned PRESCALE_BITS = 11
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic Clear,
  output logic Tick
);

  logic [PRESCALE_BITS-1:0] count_q;

  assign Tick = Enable & (&count_q);

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count_q <= '0;
    end else if (Enable) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the reaction-time game: random arm delay, GO lamp,
// Stop response measured in prescaled ticks, with false-start and timeout handling.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_BITS = 11,
  parameter int unsigned TIME_WIDTH    = DEFAULT_TIME_WIDTH,
  parameter int unsigned MIN_WAIT      = DEFAULT_MIN_WAIT,
  parameter int unsigned LFSR_WIDTH    = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Stop,
  output logic                  GoLed,
  output logic                  FoulLed,
  output logic                  ResultValid,
  output logic [TIME_WIDTH-1:0] ReactionTime,
  output logic                  Busy
);

  state_e                  state_q;
  logic                    start_q, stop_q;
  logic                    start_rise, stop_rise;
  logic [LFSR_WIDTH-1:0]   lfsr_q;
  logic [TIME_WIDTH-1:0]   wait_cnt_q, react_cnt_q, wait_load;
  logic                    run, tick, clear;

  assign start_rise = Start & ~start_q;
  assign stop_rise  = Stop & ~stop_q;
  assign wait_load  = TIME_WIDTH'(MIN_WAIT) + TIME_WIDTH'(lfsr_q);
  assign run        = (state_q == StWait) || (state_q == StGo);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      lfsr_q  <= LFSR_WIDTH'(1);
    end else begin
      start_q <= Start;
      stop_q  <= Stop;
      lfsr_q  <= {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_WIDTH'(LFSR_TAPS))};
    end
  end

  // Restart the prescaler on the same edge that enters WAIT or GO
  always_comb begin
    clear = 1'b0;
    unique case (state_q)
      StIdle, StResult, StFoul: clear = start_rise;
      StWait:  clear = ~stop_rise & tick & (wait_cnt_q == TIME_WIDTH'(1));
      default: clear = 1'b0;
    endcase
  end

  tick_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .Clock (Clock),
    .Reset (Reset),
    .Enable(run),
    .Clear (clear),
    .Tick  (tick)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      react_cnt_q  <= '0;
      GoLed        <= 1'b0;
      FoulLed      <= 1'b0;
      ResultValid  <= 1'b0;
      Busy         <= 1'b0;
      ReactionTime <= '0;
    end else begin
      unique case (state_q)
        StIdle, StResult, StFoul: begin
          if (start_rise) begin
            state_q     <= StWait;
            wait_cnt_q  <= wait_load;
            FoulLed     <= 1'b0;
            ResultValid <= 1'b0;
            Busy        <= 1'b1;
          end
        end
        StWait: begin
          if (stop_rise) begin
            state_q <= StFoul;
            FoulLed <= 1'b1;
            Busy    <= 1'b0;
          end else if (tick) begin
            if (wait_cnt_q == TIME_WIDTH'(1)) begin
              state_q     <= StGo;
              react_cnt_q <= '0;
              GoLed       <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q - TIME_WIDTH'(1);
            end
          end
        end
        StGo: begin
          if (stop_rise) begin
            state_q      <= StResult;
            ReactionTime <= react_cnt_q;
            GoLed        <= 1'b0;
            Busy         <= 1'b0;
            ResultValid  <= 1'b1;
          end else if (tick) begin
            if (&react_cnt_q) begin
              // Timeout: saturate the reported time
              state_q      <= StResult;
              ReactionTime <= '1;
              GoLed        <= 1'b0;
              Busy         <= 1'b0;
              ResultValid  <= 1'b1;
            end else begin
              react_cnt_q <= react_cnt_q + TIME_WIDTH'(1);
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          GoLed       <= 1'b0;
          FoulLed     <= 1'b0;
          ResultValid <= 1'b0;
          Busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
